serializer_p2s: RTL and testbench



---
 rtl/serializer_p2s_if.sv | 10 +
 rtl/serializer_p2s.sv | 62 ++++++
 tb/tb_serializer_p2s.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serializer_p2s_if.sv
// serializer_p2s_if: parallel word handshake in, serial bit stream out
interface serializer_p2s_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic out;
  logic out_valid;
  modport master (output din, din_valid, input din_ready, out, out_valid);
  modport slave (input din, din_valid, output din_ready, out, out_valid);
endinterface

// File: rtl/serializer_p2s.sv
// serializer_p2s: valid/ready parallel-to-serial shifter with one-word holding register
module serializer_p2s #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  serializer_p2s_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sh, r_hold;
  logic [5:0]       r_idx;
  logic             r_hold_full, r_out, r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_last, w_load, w_take_din, w_front;
  logic [WIDTH-1:0] w_src, w_rest;
  assign bus.din_ready = ~r_hold_full & ~rst;
  assign w_accept      = bus.din_valid & bus.din_ready;
  assign w_last        = (r_state == SHIFT) && (r_idx == 6'(WIDTH));
  // a new word starts from idle or right after the last bit, preferring the held word
  assign w_load        = ((r_state == IDLE) | w_last) & (r_hold_full | w_accept);
  assign w_take_din    = w_load & ~r_hold_full & w_accept;
  assign w_src         = w_load ? (r_hold_full ? r_hold : bus.din) : r_sh;
  assign w_front       = (MSB_FIRST != 0) ? w_src[WIDTH-1] : w_src[0];
  assign w_rest        = (MSB_FIRST != 0) ? w_src << 1 : w_src >> 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out       <= IDLE_LEVEL;
      r_out_valid <= 1'b0;
      r_hold_full <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_load || (r_state == SHIFT && !w_last)) begin
        r_state     <= SHIFT;
        r_out       <= w_front;
        r_out_valid <= 1'b1;
        r_sh        <= w_rest;
        r_idx       <= w_load ? 6'd1 : r_idx + 6'd1;
      end else if (w_last) begin
        r_state     <= IDLE;
        r_out       <= IDLE_LEVEL;
        r_out_valid <= 1'b0;
        r_idx       <= '0;
      end
      if (w_last) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept & ~w_take_din) r_hold <= bus.din;
      r_hold_full <= (r_hold_full & ~w_load) | (w_accept & ~w_take_din);
    end
  end
  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign busy          = (r_state == SHIFT) | r_hold_full;
  assign word_cnt      = r_cnt;
endmodule

// File: tb/tb_serializer_p2s.sv
// tb_serializer_p2s: scoreboard bench for an MSB-first and an LSB-first/2-bit-counter instance
module tb_serializer_p2s;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serializer_p2s_if #(.WIDTH(8)) ifa ();
  serializer_p2s_if #(.WIDTH(8)) ifb ();
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  serializer_p2s #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1), .CNT_W(16)) ua (
    .clk(clk), .rst(rst), .bus(ifa.slave), .busy(busy_a), .word_cnt(cnt_a));
  serializer_p2s #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .CNT_W(2)) ub (
    .clk(clk), .rst(rst), .bus(ifb.slave), .busy(busy_b), .word_cnt(cnt_b));
  bit q [2][$];
  int mark [2];
  int rd [2];
  int base [2];
  int seen [2];
  int rst_cnt = 0;
  int checks = 0;
  int errors = 0;
  task automatic cmp(string name, int k, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, got, exp);
    end
  endtask
  // expected line state follows from the queue of accepted-but-unshown bits
  task automatic chk(int k, logic o, logic ov, logic bz, logic rdy, int cnt, logic idle_lvl, int mask);
    bit exp_v, exp_o;
    if (rst_cnt != seen[k]) begin
      seen[k] = rst_cnt;
      rd[k]   = mark[k];
      base[k] = mark[k];
    end
    exp_v = q[k].size() > rd[k];
    cmp("word_cnt", k, cnt, ((rd[k] - base[k]) / 8) & mask);
    exp_o = exp_v ? q[k][rd[k]] : idle_lvl;
    if (exp_v) rd[k]++;
    cmp("out", k, int'(o), int'(exp_o));
    cmp("out_valid", k, int'(ov), int'(exp_v));
    cmp("busy", k, int'(bz), int'(exp_v));
    cmp("din_ready", k, int'(rdy), int'(!rst && (q[k].size() - rd[k]) < 8));
  endtask
  always @(negedge clk) begin
    if (rst_cnt > 0) begin
      chk(0, ifa.out, ifa.out_valid, busy_a, ifa.din_ready, int'(cnt_a), 1'b1, 16'hFFFF);
      chk(1, ifb.out, ifb.out_valid, busy_b, ifb.din_ready, int'(cnt_b), 1'b0, 3);
    end
  end
  task automatic set_in(logic v, logic [7:0] d);
    ifa.din_valid = v;
    ifb.din_valid = v;
    ifa.din = d;
    ifb.din = d;
  endtask
  task automatic tick(output logic acc);
    #6;
    acc = ifa.din_valid && ifa.din_ready;
    if (rst) begin
      for (int k = 0; k < 2; k++) mark[k] = q[k].size();
      rst_cnt++;
    end else begin
      if (acc) for (int i = 7; i >= 0; i--) q[0].push_back(ifa.din[i]);
      if (ifb.din_valid && ifb.din_ready) for (int i = 0; i < 8; i++) q[1].push_back(ifb.din[i]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    logic a;
    repeat (n) tick(a);
  endtask
  task automatic pulse_rst();
    logic a;
    rst = 1'b1;
    tick(a);
    rst = 1'b0;
  endtask
  task automatic send(logic [7:0] w);
    logic acc;
    int n;
    set_in(1'b1, w);
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 100);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout t=%0t: got no accept expected accept of %0h", $time, w);
    end
    set_in(1'b0, 8'($urandom));
  endtask
  initial begin
    set_in(1'b0, 8'h00);
    @(posedge clk);
    #1;
    idle(3);
    rst = 1'b0;
    idle(2);
    send(8'b0110_0110);
    idle(12);
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    idle(30);
    send(8'h0F);
    send(8'hAA);
    idle(1);
    pulse_rst();
    idle(3);
    send(8'h81);
    idle(12);
    for (int i = 0; i < 5; i++) send(8'(i * 37 + 1));
    idle(12);
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) begin
        idle($urandom_range(0, 9));
        pulse_rst();
      end
      send(8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(30);
    cmp("drained", 0, rd[0], q[0].size());
    cmp("drained", 1, rd[1], q[1].size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
